// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve unit: MIPS branch opcodes,
// REGIMM rt sub-codes and the 2-bit BHT counter encodings.
package branch_resolve_unit_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // 2-bit saturating counter: upper bit is the predicted direction
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Decode-side request and resolution result bundle for branch_resolve_unit.
// master: pipeline side (drives the instruction, receives the resolution)
// slave:  branch_resolve_unit
interface branch_resolve_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              valid_i;
  logic              stall_i;
  logic              flush_i;
  logic [5:0]        op_i;
  logic [4:0]        rt_i;
  logic [DATA_W-1:0] a_i;
  logic [DATA_W-1:0] b_i;
  logic [31:0]       pc_i;
  logic              pred_taken_i;

  logic              res_valid_o;
  logic              taken_o;
  logic              mispredict_o;
  logic              link_o;
  logic [31:0]       res_pc_o;

  modport master (
    output valid_i, stall_i, flush_i, op_i, rt_i, a_i, b_i, pc_i, pred_taken_i,
    input  res_valid_o, taken_o, mispredict_o, link_o, res_pc_o
  );

  modport slave (
    input  valid_i, stall_i, flush_i, op_i, rt_i, a_i, b_i, pc_i, pred_taken_i,
    output res_valid_o, taken_o, mispredict_o, link_o, res_pc_o
  );
endinterface

// File: rtl/branch_resolve_unit_branch_cond.sv
// branch_cond: purely combinational MIPS branch decode and condition
// evaluation on signed DATA_W-bit operands.
module branch_cond
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [5:0]        op,
  input  logic [4:0]        rt,
  output logic              cond,
  output logic              is_br,
  output logic              is_link
);

  logic a_neg;
  logic a_zero;

  // Signed compares against zero reduce to the sign bit and a zero test
  always_comb begin
    a_neg  = a[DATA_W-1];
    a_zero = (a == '0);
  end

  // Decode the op/rt pair and select the matching condition
  always_comb begin
    cond    = 1'b0;
    is_br   = 1'b0;
    is_link = 1'b0;
    unique case (op)
      OP_BEQ:  begin is_br = 1'b1; cond = (a == b);          end
      OP_BNE:  begin is_br = 1'b1; cond = (a != b);          end
      OP_BGTZ: begin is_br = 1'b1; cond = ~a_neg & ~a_zero;  end
      OP_BLEZ: begin is_br = 1'b1; cond = a_neg | a_zero;    end
      OP_REGIMM: begin
        unique case (rt)
          RT_BLTZ:   begin is_br = 1'b1; cond = a_neg;                   end
          RT_BGEZ:   begin is_br = 1'b1; cond = ~a_neg;                  end
          RT_BLTZAL: begin is_br = 1'b1; cond = a_neg;  is_link = 1'b1;  end
          RT_BGEZAL: begin is_br = 1'b1; cond = ~a_neg; is_link = 1'b1;  end
          default:   ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID/EX branch resolution with a 2-bit saturating
// branch history table and a combinational fetch-side lookup port.
// Optional build macro BRU_STATS_EN adds branch / mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IDX_W   = 6,
  parameter logic [1:0]  CTR_RST = 2'b01
) (
  input  logic                    clk,
  input  logic                    rst,
  branch_resolve_unit_if.slave    bus,
  input  logic [31:0]             lookup_pc_i,
  output logic                    lookup_taken_o
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]             br_count_o,
  output logic [31:0]             mispred_count_o
`endif
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic             cond;
  logic             is_br;
  logic             is_link;
  logic             capture;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] look_idx;
  ctr_t             cur_ctr;
  ctr_t             nxt_ctr;
  ctr_t             bht [DEPTH];
  logic             unused_lookup_bits;

  branch_cond #(
    .DATA_W (DATA_W)
  ) u_cond (
    .a       (bus.a_i),
    .b       (bus.b_i),
    .op      (bus.op_i),
    .rt      (bus.rt_i),
    .cond    (cond),
    .is_br   (is_br),
    .is_link (is_link)
  );

  // Capture qualification and BHT index extraction
  always_comb begin
    capture            = bus.valid_i & is_br & ~bus.stall_i & ~bus.flush_i;
    upd_idx            = bus.pc_i[IDX_W+1:2];
    look_idx           = lookup_pc_i[IDX_W+1:2];
    unused_lookup_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};
  end

  // Fetch-side prediction reads the stored counter; no update bypass
  always_comb begin
    lookup_taken_o = (bht[look_idx] == WT) || (bht[look_idx] == ST);
  end

  // Saturating counter step for the entry being resolved
  always_comb begin
    cur_ctr = bht[upd_idx];
    nxt_ctr = cur_ctr;
    unique case (cur_ctr)
      SNT: nxt_ctr = cond ? WNT : SNT;
      WNT: nxt_ctr = cond ? WT  : SNT;
      WT:  nxt_ctr = cond ? ST  : WNT;
      ST:  nxt_ctr = cond ? ST  : WT;
      default: nxt_ctr = cur_ctr;
    endcase
  end

  // Result stage: one-cycle pulse; flags cleared when nothing is captured
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_valid_o  <= 1'b0;
      bus.taken_o      <= 1'b0;
      bus.mispredict_o <= 1'b0;
      bus.link_o       <= 1'b0;
      bus.res_pc_o     <= '0;
    end else begin
      bus.res_valid_o  <= capture;
      bus.taken_o      <= capture & cond;
      bus.mispredict_o <= capture & (cond ^ bus.pred_taken_i);
      bus.link_o       <= capture & is_link;
      if (capture) begin
        bus.res_pc_o <= bus.pc_i;
      end
    end
  end

  // BHT: whole table returns to CTR_RST on reset; one entry trained per capture
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bht[IDX_W'(i)] <= ctr_t'(CTR_RST);
      end
    end else if (capture) begin
      bht[upd_idx] <= nxt_ctr;
    end
  end

`ifdef BRU_STATS_EN
  // Saturating branch and mispredict counters
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_o      <= '0;
      mispred_count_o <= '0;
    end else if (capture) begin
      if (br_count_o != '1) begin
        br_count_o <= br_count_o + 32'd1;
      end
      if ((cond ^ bus.pred_taken_i) && (mispred_count_o != '1)) begin
        mispred_count_o <= mispred_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table,
// hand-written corner sequences and randomized traffic against a
// behavioural model. Define BRU_STATS_EN to also check the counters.
module tb_branch_resolve_unit;

  typedef struct {
    bit          valid, stall, flush;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] a, b, pc;
    bit          pred;
    logic [31:0] lpc;
    bit          e_look, e_val, e_tk, e_mis, e_lnk;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
`ifdef BRU_STATS_EN
  logic [31:0] br_count;
  logic [31:0] mispred_count;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          bht_m [64];
  bit          m_valid, m_taken, m_mis, m_link;
  logic [31:0] m_pc;
  longint      m_brc, m_misc;

  branch_resolve_unit_if #(.DATA_W(32)) bus ();

  branch_resolve_unit #(
    .DATA_W  (32),
    .IDX_W   (6),
    .CTR_RST (2'b01)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .lookup_pc_i    (lookup_pc),
    .lookup_taken_o (lookup_taken)
`ifdef BRU_STATS_EN
    ,
    .br_count_o      (br_count),
    .mispred_count_o (mispred_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit va, bit st, bit fl, logic [5:0] op, logic [4:0] rt,
                              logic [31:0] a, logic [31:0] b, logic [31:0] pc, bit pr,
                              logic [31:0] lpc, bit el, bit ev, bit et, bit em, bit ek);
    vec_t v;
    v.valid = va; v.stall = st; v.flush = fl; v.op = op; v.rt = rt;
    v.a = a; v.b = b; v.pc = pc; v.pred = pr; v.lpc = lpc;
    v.e_look = el; v.e_val = ev; v.e_tk = et; v.e_mis = em; v.e_lnk = ek;
    return v;
  endfunction

  // MIPS branch semantics from the ISA definition, signed integer arithmetic
  function automatic void ref_eval(input logic [5:0] op, input logic [4:0] rt,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output bit br, output bit tk, output bit lk);
    int sa;
    sa = a;
    br = 0; tk = 0; lk = 0;
    case (op)
      6'd4: begin br = 1; tk = (a == b); end
      6'd5: begin br = 1; tk = (a != b); end
      6'd7: begin br = 1; tk = (sa > 0);  end
      6'd6: begin br = 1; tk = (sa <= 0); end
      6'd1: case (rt)
              5'd0:  begin br = 1; tk = (sa < 0);  end
              5'd1:  begin br = 1; tk = (sa >= 0); end
              5'd16: begin br = 1; tk = (sa < 0);  lk = 1; end
              5'd17: begin br = 1; tk = (sa >= 0); lk = 1; end
              default: ;
            endcase
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    foreach (bht_m[i]) bht_m[i] = 1;
    m_valid = 0; m_taken = 0; m_mis = 0; m_link = 0; m_pc = 0;
    m_brc = 0; m_misc = 0;
  endtask

  // Apply one vector for one clock, check pre-edge lookup and post-edge result
  task automatic cycle(input vec_t v, input bit r, output logic look_pre);
    bit br, tk, lk, cap;
    int idx;
    rst              = r;
    bus.valid_i      = v.valid;
    bus.stall_i      = v.stall;
    bus.flush_i      = v.flush;
    bus.op_i         = v.op;
    bus.rt_i         = v.rt;
    bus.a_i          = v.a;
    bus.b_i          = v.b;
    bus.pc_i         = v.pc;
    bus.pred_taken_i = v.pred;
    lookup_pc        = v.lpc;
    #1;
    look_pre = lookup_taken;
    chk("lookup", {31'd0, look_pre}, {31'd0, bht_m[v.lpc[7:2]] >= 2});
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      ref_eval(v.op, v.rt, v.a, v.b, br, tk, lk);
      cap     = v.valid && br && !v.stall && !v.flush;
      m_valid = cap;
      m_taken = cap && tk;
      m_mis   = cap && (tk != v.pred);
      m_link  = cap && lk;
      if (cap) begin
        m_pc = v.pc;
        idx  = v.pc[7:2];
        if (tk) bht_m[idx] = (bht_m[idx] < 3) ? bht_m[idx] + 1 : 3;
        else    bht_m[idx] = (bht_m[idx] > 0) ? bht_m[idx] - 1 : 0;
        m_brc = (m_brc < 64'hFFFF_FFFF) ? m_brc + 1 : m_brc;
        if (tk != v.pred) m_misc = (m_misc < 64'hFFFF_FFFF) ? m_misc + 1 : m_misc;
      end
    end
    chk("res_valid",  {31'd0, bus.res_valid_o},  {31'd0, m_valid});
    chk("taken",      {31'd0, bus.taken_o},      {31'd0, m_taken});
    chk("mispredict", {31'd0, bus.mispredict_o}, {31'd0, m_mis});
    chk("link",       {31'd0, bus.link_o},       {31'd0, m_link});
    chk("res_pc",     bus.res_pc_o,              m_pc);
`ifdef BRU_STATS_EN
    chk("br_count",      br_count,      m_brc[31:0]);
    chk("mispred_count", mispred_count, m_misc[31:0]);
`endif
  endtask

  function automatic logic [31:0] pick_a();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t        tbl [$];
    vec_t        idle;
    vec_t        v;
    logic        lp;
    logic [5:0]  ops [8];
    logic [4:0]  rts [5];

    idle = mk(0,0,0, 6'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0,0,0,0,0);
    model_reset();

    // Bring the DUT out of X before the first model-checked cycle
    rst = 1'b1;
    bus.valid_i = 0; bus.stall_i = 0; bus.flush_i = 0; bus.op_i = 0; bus.rt_i = 0;
    bus.a_i = 0; bus.b_i = 0; bus.pc_i = 0; bus.pred_taken_i = 0; lookup_pc = 0;
    @(posedge clk);
    #1;
    cycle(idle, 1'b1, lp);
    chk("reset_lookup", {31'd0, lp}, 32'd0);

    // valid stall flush op rt a b pc pred lpc | look val tk mis lnk
    tbl.push_back(mk(1,0,0, 6'd4, 5'd0,  32'h5,         32'h5, 32'h100, 0, 32'h100, 0,1,1,1,0));
    tbl.push_back(mk(1,0,0, 6'd0, 5'd0,  32'h0,         32'h0, 32'h100, 0, 32'h100, 1,0,0,0,0));
    tbl.push_back(mk(1,0,0, 6'd7, 5'd0,  32'h8000_0000, 32'h0, 32'h208, 0, 32'h208, 0,1,0,0,0));
    tbl.push_back(mk(1,0,0, 6'd1, 5'd16, 32'h8000_0000, 32'h0, 32'h20C, 1, 32'h208, 0,1,1,0,1));
    tbl.push_back(mk(1,0,0, 6'd5, 5'd0,  32'h1,         32'h2, 32'h104, 0, 32'h104, 0,1,1,1,0));
    tbl.push_back(mk(1,0,0, 6'd5, 5'd0,  32'h1,         32'h2, 32'h104, 0, 32'h104, 1,1,1,1,0));
    tbl.push_back(mk(1,0,0, 6'd5, 5'd0,  32'h1,         32'h2, 32'h104, 0, 32'h104, 1,1,1,1,0));
    tbl.push_back(mk(1,0,0, 6'd5, 5'd0,  32'h1,         32'h2, 32'h104, 0, 32'h104, 1,1,1,1,0));
    tbl.push_back(mk(1,0,0, 6'd5, 5'd0,  32'h3,         32'h3, 32'h104, 1, 32'h104, 1,1,0,1,0));
    tbl.push_back(mk(1,0,0, 6'd5, 5'd0,  32'h3,         32'h3, 32'h104, 1, 32'h104, 1,1,0,1,0));
    tbl.push_back(mk(1,0,0, 6'd5, 5'd0,  32'h3,         32'h3, 32'h104, 1, 32'h104, 0,1,0,1,0));
    tbl.push_back(mk(1,0,0, 6'd5, 5'd0,  32'h3,         32'h3, 32'h104, 1, 32'h104, 0,1,0,1,0));
    tbl.push_back(mk(1,0,0, 6'd5, 5'd0,  32'h3,         32'h3, 32'h104, 1, 32'h104, 0,1,0,1,0));
    tbl.push_back(mk(1,0,0, 6'd0, 5'd0,  32'h0,         32'h0, 32'h0,   0, 32'h104, 0,0,0,0,0));
    tbl.push_back(mk(1,1,0, 6'd4, 5'd0,  32'h9,         32'h9, 32'h110, 0, 32'h110, 0,0,0,0,0));
    tbl.push_back(mk(1,0,1, 6'd4, 5'd0,  32'h9,         32'h9, 32'h110, 0, 32'h110, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0, 6'd1, 5'd3,  32'h0,         32'h0, 32'h110, 0, 32'h110, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 6'd4, 5'd0,  32'h9,         32'h9, 32'h110, 0, 32'h110, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0, 6'd6, 5'd0,  32'h0,         32'h0, 32'h114, 1, 32'h110, 0,1,1,0,0));
    tbl.push_back(mk(1,0,0, 6'd1, 5'd1,  32'hFFFF_FFFF, 32'h0, 32'h118, 1, 32'h114, 1,1,0,1,0));
    tbl.push_back(mk(1,0,0, 6'd1, 5'd17, 32'h0,         32'h0, 32'h118, 0, 32'h118, 0,1,1,1,1));
    tbl.push_back(mk(1,0,0, 6'd1, 5'd0,  32'h7FFF_FFFF, 32'h0, 32'h11C, 0, 32'h0,   1,1,0,0,0));
    tbl.push_back(mk(0,0,0, 6'd0, 5'd0,  32'h0,         32'h0, 32'h0,   0, 32'h118, 0,0,0,0,0));

    foreach (tbl[i]) begin
      cycle(tbl[i], 1'b0, lp);
      chk($sformatf("tbl%0d_look", i),  {31'd0, lp},                {31'd0, tbl[i].e_look});
      chk($sformatf("tbl%0d_valid", i), {31'd0, bus.res_valid_o},  {31'd0, tbl[i].e_val});
      chk($sformatf("tbl%0d_taken", i), {31'd0, bus.taken_o},      {31'd0, tbl[i].e_tk});
      chk($sformatf("tbl%0d_mis", i),   {31'd0, bus.mispredict_o}, {31'd0, tbl[i].e_mis});
      chk($sformatf("tbl%0d_link", i),  {31'd0, bus.link_o},       {31'd0, tbl[i].e_lnk});
    end

    // Same-index lookup and update: old value this cycle, new value next
    v = mk(1,0,0, 6'd4, 5'd0, 32'h7, 32'h7, 32'h130, 0, 32'h130, 0,0,0,0,0);
    cycle(v, 1'b0, lp);
    chk("same_idx_before", {31'd0, lp}, 32'd0);
    chk("same_idx_after", {31'd0, lookup_taken}, 32'd1);

    // Reset colliding with a capture on a trained entry
    v = mk(1,0,0, 6'd4, 5'd0, 32'h1, 32'h1, 32'h100, 0, 32'h100, 0,0,0,0,0);
    cycle(v, 1'b1, lp);
    chk("rst_cap_valid", {31'd0, bus.res_valid_o}, 32'd0);
    rst = 1'b0;
    bus.valid_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      lookup_pc = 32'(i) << 2;
      #1;
      chk($sformatf("rst_entry%0d", i), {31'd0, lookup_taken}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Three branches, one mispredicted
    v = mk(1,0,0, 6'd4, 5'd0, 32'h4, 32'h4, 32'h140, 1, 32'h0, 0,0,0,0,0);
    cycle(v, 1'b0, lp);
    v = mk(1,0,0, 6'd5, 5'd0, 32'h4, 32'h4, 32'h144, 0, 32'h0, 0,0,0,0,0);
    cycle(v, 1'b0, lp);
    v = mk(1,0,0, 6'd7, 5'd0, 32'h5, 32'h0, 32'h148, 0, 32'h0, 0,0,0,0,0);
    cycle(v, 1'b0, lp);
    chk("three_br_mis", {31'd0, bus.mispredict_o}, 32'd1);
`ifdef BRU_STATS_EN
    chk("stats_br", br_count, 32'd3);
    chk("stats_mis", mispred_count, 32'd1);
`endif

    // Randomized traffic against the model
    ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd0, 6'd2, 6'd35};
    rts = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd3};
    for (int n = 0; n < 500; n++) begin
      v.valid = ($urandom_range(0, 9) != 0);
      v.stall = ($urandom_range(0, 6) == 0);
      v.flush = ($urandom_range(0, 9) == 0);
      v.op    = ops[$urandom_range(0, 7)];
      v.rt    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : rts[$urandom_range(0, 4)];
      v.a     = pick_a();
      v.b     = $urandom_range(0, 1) ? v.a : pick_a();
      v.pc    = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      v.pred  = $urandom_range(0, 1);
      v.lpc   = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      cycle(v, ($urandom_range(0, 49) == 0), lp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Next-generation branch comparator for the MIPS core. Evaluates all MIPS conditional branch conditions on DATA_W-bit operands using signed two's-complement compare.
- Contains a parametrised 2-bit saturating branch history table (BHT) used for fetch-side prediction.
- Registers the branch resolution and reports mispredicts to the pipeline control and hazard unit.
- Sits at the ID/EX boundary. The fetch stage reads the BHT through a separate combinational lookup port.

Parameters:
- DATA_W, 32: operand width in bits.
- IDX_W, 6: BHT index width; the table has 2**IDX_W entries.
- CTR_RST, 2'b01: counter value after reset (weakly not-taken).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  decode-stage instruction valid
- stall_i  in  1  decode stage stalled; blocks capture
- flush_i  in  1  pipeline flush; kills capture this cycle
- op_i  in  6  instruction opcode
- rt_i  in  5  rt field, used for REGIMM decode
- a_i  in  DATA_W  rs operand, already forwarded
- b_i  in  DATA_W  rt operand, already forwarded
- pc_i  in  32  branch PC
- pred_taken_i  in  1  prediction carried down from fetch
- lookup_pc_i  in  32  fetch PC for prediction
- lookup_taken_o  out  1  predicted direction for lookup_pc_i
- res_valid_o  out  1  resolution valid (one-cycle pulse)
- taken_o  out  1  resolved direction
- mispredict_o  out  1  taken_o differs from the registered pred_taken_i
- link_o  out  1  resolved instruction is BLTZAL or BGEZAL
- res_pc_o  out  32  PC of the resolved branch

Behaviour:
- Branch set: BEQ (a==b), BNE (a!=b), BGTZ (a>0), BLEZ (a<=0). Under REGIMM: BLTZ/BLTZAL (a<0) and BGEZ/BGEZAL (a>=0).
- All magnitude compares are signed on DATA_W bits. Example: a = 32'h8000_0000 is < 0.
- is_br is 1 only for the listed op/rt combinations. REGIMM with any other rt counts as not a branch.
- capture = valid_i & is_br & ~stall_i & ~flush_i.
- Latency is 1 cycle. On the edge where capture=1, the unit registers:
  - res_valid_o = 1
  - taken_o = condition result
  - mispredict_o = condition ^ pred_taken_i
  - link_o
  - res_pc_o = pc_i
- On any edge where capture=0, res_valid_o = 0. taken_o, mispredict_o and link_o are also forced to 0. res_pc_o holds its value.
- Reset values: res_valid_o, taken_o, mispredict_o and link_o = 0; res_pc_o = 0; every BHT entry = CTR_RST.
- rst takes priority over capture and over BHT update on the same edge.
- A reset mid-stream discards any in-flight resolution and returns the whole table to CTR_RST.
- BHT index = pc[IDX_W+1:2] for both the lookup port and the update path.
- On a capture edge, entry[idx(pc_i)] is updated:
  - taken: saturating increment (3 stays 3)
  - not taken: saturating decrement (0 stays 0)
- lookup_taken_o = entry[idx(lookup_pc_i)][1], combinational.
- Simultaneous lookup and update of the same index returns the pre-update value; there is no bypass.
- A non-branch, stalled or flushed instruction never updates the BHT.

Optional Feature:
- Macro: BRU_STATS_EN.
- When defined, the unit adds output ports br_count_o[31:0] and mispred_count_o[31:0].
  - br_count_o increments on every capture.
  - mispred_count_o increments on every capture that mispredicts.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined, neither the ports nor the counters exist, and all other behaviour is identical.

Decomposition:
- defines.h holds the opcode constants `BEQ, `BNE, `BGTZ, `BLEZ and `REGIMM_INST, plus the rt constants `BLTZ, `BGEZ, `BLTZAL and `BGEZAL.
- defines.h also holds the 2-bit counter encodings: SNT=00, WNT=01, WT=10, ST=11.
- One sub-module, branch_cond: purely combinational. Takes a, b, op and rt; returns cond, is_br and is_link. All sequential logic (result stage, BHT, stats) stays in branch_resolve_unit.

Test Plan:
1. Reset, then BEQ with a=b=32'h5 and pred_taken_i=0 at pc 0x100 → next cycle res_valid_o=1, taken_o=1, mispredict_o=1, res_pc_o=0x100; entry[0] goes 01→10, and lookup_pc_i=0x100 then gives lookup_taken_o=1.
2. BGTZ with a=32'h8000_0000 → taken_o=0 (signed). BLTZAL with the same a → taken_o=1, link_o=1.
3. Four taken BNE at pc 0x104 → entry[1] saturates at 11. Then five not-taken → entry[1] saturates at 00, and lookup_taken_o=0.
4. BEQ with stall_i=1, and separately with flush_i=1 → res_valid_o stays 0 and the BHT is unchanged. REGIMM with rt=5'b00011 → no result and no update.
5. Lookup and update of the same index in one cycle while the entry is 01 and the branch is taken → lookup_taken_o=0 that cycle and 1 the next.
6. rst asserted in the same cycle as a capture → res_valid_o=0 and all entries=01. With BRU_STATS_EN: 3 branches including 1 mispredict → br_count_o=3, mispred_count_o=1.
